// File: rtl/ctrl_uart_decoder.sv
// ctrl_uart_decoder: 8N1 UART receiver feeding a small ASCII command parser.
// Each message "<ch><hex_hi><hex_lo>\n" with ch in '0'..'6' loads one byte
// into out[ch]. CR bytes are ignored, and malformed messages are dropped.
module ctrl_uart_decoder #(
  parameter int fCLK  = 50_000_000,
  parameter int fBAUD = 9_600
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       CTRL_RX,
  output logic [7:0] out [0:6]
);

  // Oversampling divider, rounded to the nearest integer.
  localparam int N_TICK = (fCLK + 8 * fBAUD) / (16 * fBAUD);
  localparam int TICK_W = (N_TICK > 1) ? $clog2(N_TICK) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(N_TICK - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {WAIT_CH, WAIT_HI, WAIT_LO, WAIT_END} dec_state_t;

  // Returns {valid, nibble} for an ASCII hex digit.
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    logic [4:0] r;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r = {1'b1, c[3:0] + 4'd9};
    end else begin
      r = 5'b0_0000;
    end
    return r;
  endfunction

  logic [TICK_W-1:0] tick_cnt_r;
  logic              ce_16_r;
  logic              rx_meta_r, rx_sync_r;
  rx_state_t         rx_state_r, rx_nxt_s;
  logic [3:0]        rx_tick_r;
  logic [2:0]        rx_bit_r;
  logic [7:0]        rx_shift_r, rx_data_r;
  logic              rx_new_r;
  logic              rx_tick_clr_s, rx_tick_inc_s, rx_shift_s, rx_done_s;
  dec_state_t        dec_state_r, dec_nxt_s;
  logic [2:0]        ch_r;
  logic [3:0]        hi_r, lo_r;
  logic              ch_ld_s, hi_ld_s, lo_ld_s, wr_s;
  logic [4:0]        hex_s;

  // Free-running oversample divider; ce_16_r pulses once every N_TICK clocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_r <= {TICK_W{1'b0}};
      ce_16_r    <= 1'b0;
    end else if (tick_cnt_r == TICK_LAST) begin
      tick_cnt_r <= {TICK_W{1'b0}};
      ce_16_r    <= 1'b1;
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_W'(1);
      ce_16_r    <= 1'b0;
    end
  end

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= CTRL_RX;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_r <= RX_IDLE;
    end else begin
      rx_state_r <= rx_nxt_s;
    end
  end

  // Receiver next-state and datapath controls; only acts on oversample ticks.
  always_comb begin
    rx_nxt_s      = rx_state_r;
    rx_tick_clr_s = 1'b0;
    rx_tick_inc_s = 1'b0;
    rx_shift_s    = 1'b0;
    rx_done_s     = 1'b0;
    if (ce_16_r) begin
      case (rx_state_r)
        RX_IDLE: begin
          if (!rx_sync_r) begin
            rx_nxt_s      = RX_START;
            rx_tick_clr_s = 1'b1;
          end else begin
            rx_nxt_s = RX_IDLE;
          end
        end
        RX_START: begin
          if (rx_tick_r == 4'd7) begin
            rx_tick_clr_s = 1'b1;
            rx_nxt_s      = rx_sync_r ? RX_IDLE : RX_DATA;
          end else begin
            rx_tick_inc_s = 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_tick_r == 4'd15) begin
            rx_tick_clr_s = 1'b1;
            rx_shift_s    = 1'b1;
            rx_nxt_s      = (rx_bit_r == 3'd7) ? RX_STOP : RX_DATA;
          end else begin
            rx_tick_inc_s = 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_tick_r == 4'd15) begin
            rx_tick_clr_s = 1'b1;
            rx_done_s     = rx_sync_r;
            rx_nxt_s      = RX_IDLE;
          end else begin
            rx_tick_inc_s = 1'b1;
          end
        end
        default: begin
          rx_nxt_s = RX_IDLE;
        end
      endcase
    end else begin
      rx_nxt_s = rx_state_r;
    end
  end

  // Receiver tick/bit counters, shift register and byte-valid pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_tick_r  <= 4'd0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
      rx_data_r  <= 8'h00;
      rx_new_r   <= 1'b0;
    end else begin
      if (rx_tick_clr_s) begin
        rx_tick_r <= 4'd0;
      end else if (rx_tick_inc_s) begin
        rx_tick_r <= rx_tick_r + 4'd1;
      end
      if (rx_state_r == RX_START) begin
        rx_bit_r <= 3'd0;
      end else if (rx_shift_s) begin
        rx_bit_r <= rx_bit_r + 3'd1;
      end
      if (rx_shift_s) begin
        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
      end
      if (rx_done_s) begin
        rx_data_r <= rx_shift_r;
      end
      rx_new_r <= rx_done_s;
    end
  end

  // Decoder state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_state_r <= WAIT_CH;
    end else begin
      dec_state_r <= dec_nxt_s;
    end
  end

  // Decoder next-state: advances only on a fresh byte, CR is transparent.
  always_comb begin
    dec_nxt_s = dec_state_r;
    ch_ld_s   = 1'b0;
    hi_ld_s   = 1'b0;
    lo_ld_s   = 1'b0;
    wr_s      = 1'b0;
    hex_s     = hex_nib(rx_data_r);
    if (rx_new_r && (rx_data_r != 8'h0D)) begin
      case (dec_state_r)
        WAIT_CH: begin
          if (rx_data_r >= 8'h30 && rx_data_r <= 8'h36) begin
            ch_ld_s   = 1'b1;
            dec_nxt_s = WAIT_HI;
          end else begin
            dec_nxt_s = WAIT_CH;
          end
        end
        WAIT_HI: begin
          if (hex_s[4]) begin
            hi_ld_s   = 1'b1;
            dec_nxt_s = WAIT_LO;
          end else begin
            dec_nxt_s = WAIT_CH;
          end
        end
        WAIT_LO: begin
          if (hex_s[4]) begin
            lo_ld_s   = 1'b1;
            dec_nxt_s = WAIT_END;
          end else begin
            dec_nxt_s = WAIT_CH;
          end
        end
        WAIT_END: begin
          wr_s      = (rx_data_r == 8'h0A);
          dec_nxt_s = WAIT_CH;
        end
        default: begin
          dec_nxt_s = WAIT_CH;
        end
      endcase
    end else begin
      dec_nxt_s = dec_state_r;
    end
  end

  // Message fields and the per-channel output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_r <= 3'd0;
      hi_r <= 4'd0;
      lo_r <= 4'd0;
      for (int i = 0; i < 7; i++) begin
        out[i] <= 8'h00;
      end
    end else begin
      if (ch_ld_s) begin
        ch_r <= rx_data_r[2:0];
      end
      if (hi_ld_s) begin
        hi_r <= hex_s[3:0];
      end
      if (lo_ld_s) begin
        lo_r <= hex_s[3:0];
      end
      if (wr_s && (ch_r <= 3'd6)) begin
        out[ch_r] <= {hi_r, lo_r};
      end
    end
  end

endmodule

// File: tb/tb_ctrl_uart_decoder.sv
// Bench for ctrl_uart_decoder: directed serial messages, with a scoreboard
// queue of expected channel writes drained by an independent monitor.
module tb_ctrl_uart_decoder;

  localparam int N   = 4;        // 1_600_000 / (16 * 25_000)
  localparam int BIT = 16 * N;   // clocks per serial bit

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ctrl_rx;
  logic [7:0] out_s     [0:6];
  logic [7:0] out_def_s [0:6];

  ctrl_uart_decoder #(.fCLK(1_600_000), .fBAUD(25_000)) dut (
    .clk(clk), .reset_n(reset_n), .CTRL_RX(ctrl_rx), .out(out_s)
  );

  ctrl_uart_decoder dut_def (
    .clk(clk), .reset_n(reset_n), .CTRL_RX(1'b1), .out(out_def_s)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] val;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model [0:6];
  int         total = 0;
  int         bad = 0;
  int         exp_bytes = 0;
  int         got_bytes = 0;
  int         def_pulses = 0;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("%s_out%0d", tag, i), int'(out_s[i]), int'(model[i]));
    end
  endtask

  task automatic expect_write(input int ch, input logic [7:0] val);
    exp_t e;
    e.ch  = 3'(ch);
    e.val = val;
    exp_q.push_back(e);
    model[ch] = val;
  endtask

  // stop_ok=0 drives a framing error: stop bit low for 3/4 of a bit.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clk);
    ctrl_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ctrl_rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    if (stop_ok) begin
      ctrl_rx = 1'b1;
      repeat (BIT) @(negedge clk);
      exp_bytes++;
    end else begin
      ctrl_rx = 1'b0;
      repeat (BIT * 3 / 4) @(negedge clk);
      ctrl_rx = 1'b1;
      repeat (BIT / 4) @(negedge clk);
    end
    repeat (BIT / 4) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], 1'b1);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset_n = 1'b0;
    ctrl_rx = 1'b1;
    for (int i = 0; i < 7; i++) model[i] = 8'h00;
    repeat (5) @(negedge clk);
    check_all("in_reset");
    reset_n = 1'b1;
  endtask

  // Monitor: any change on out must match the head of the scoreboard and
  // must appear one cycle after a received-byte pulse.
  initial begin
    logic [7:0] prev [0:6];
    logic       prev_new;
    int         nchg;
    int         lch;
    exp_t       e;
    for (int i = 0; i < 7; i++) prev[i] = 8'h00;
    prev_new = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        for (int i = 0; i < 7; i++) prev[i] = 8'h00;
        prev_new = 1'b0;
      end else begin
        nchg = 0;
        lch  = 0;
        for (int i = 0; i < 7; i++) begin
          if (out_s[i] != prev[i]) begin
            nchg++;
            lch = i;
          end
        end
        if (nchg > 0) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_update ch=%0d got=%0h", lch, out_s[lch]);
          end else begin
            e = exp_q.pop_front();
            check("update_nchg", nchg, 1);
            check("update_ch", lch, int'(e.ch));
            check("update_val", int'(out_s[lch]), int'(e.val));
          end
          check("update_after_pulse", int'(prev_new), 1);
        end
        if (dut.rx_new_r) got_bytes++;
        if (dut_def.rx_new_r) def_pulses++;
        prev_new = dut.rx_new_r;
        for (int i = 0; i < 7; i++) prev[i] = out_s[i];
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog_timeout got=1 want=0");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  // Directed stimulus.
  initial begin
    int cyc;
    reset_n = 1'b0;
    ctrl_rx = 1'b1;
    for (int i = 0; i < 7; i++) model[i] = 8'h00;
    repeat (5) @(negedge clk);
    check_all("reset");

    // Divider on the default-parameter instance: first tick and period.
    reset_n = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!dut_def.ce_16_r && cyc < 1000);
    check("ce16_first", cyc, 326);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!dut_def.ce_16_r && cyc < 1000);
    check("ce16_period", cyc, 326);
    check_all("idle");

    expect_write(3, 8'hA5);
    send_str("3A5\n");
    check_all("msg_3A5");

    expect_write(1, 8'hFF);
    send_str("1ff\r\n");
    send_str("7FF\n");
    check_all("msg_1ff_7FF");

    send_str("2G1\n");
    send_str("25X");
    check_all("msg_bad_hex");
    expect_write(2, 8'h0C);
    send_str("20C\n");
    check_all("msg_20C");

    // Framing error in the middle of a message, then an idle-line glitch.
    send_str("5A");
    send_byte(8'h42, 1'b0);
    send_str("\n");
    @(negedge clk);
    ctrl_rx = 1'b0;
    repeat (3 * N) @(negedge clk);
    ctrl_rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check_all("frame_glitch");
    check("byte_count_mid", got_bytes, exp_bytes);

    // Reset halfway through the second character of "4 7E\n".
    send_str("4");
    @(negedge clk);
    ctrl_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ctrl_rx = 1'b0;
      repeat (BIT) @(negedge clk);
    end
    reset_pulse();
    repeat (2 * BIT) @(negedge clk);
    expect_write(4, 8'h7E);
    send_str("47E\n");
    check_all("after_reset");

    repeat (BIT) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("byte_count", got_bytes, exp_bytes);
    check("def_no_pulse", def_pulses, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_uart_decoder.md
CTRL_UART_DECODER -- requirements
Module: ctrl_uart_decoder

Interface
REQ-001 Parameter fCLK, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter fBAUD, default 9_600, serial baud rate.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 CTRL_RX  input  1  asynchronous UART line, 8N1, LSB first, idle high.
REQ-006 out  output  7 x 8 (out[0:6])  decoded control values, one byte per channel.

Function -- baud tick
REQ-007 Internal ce_16 SHALL pulse high for exactly one clk every N clocks, N = round(fCLK/(16*fBAUD)); default N = 326.
REQ-008 The tick counter SHALL free-run from 0 after reset release; first ce_16 occurs N clocks after release.

Function -- UART receiver
REQ-009 CTRL_RX SHALL pass through a 2-flop synchronizer (reset value 1) before any use.
REQ-010 Receiver states: IDLE, START, DATA, STOP; sampling counts ce_16 ticks only.
REQ-011 IDLE -> START when the synchronized line is 0 on a ce_16 tick.
REQ-012 START: after 8 ticks, re-sample; line 1 -> IDLE (glitch rejected), line 0 -> DATA.
REQ-013 DATA: sample every 16 ticks at bit centre, 8 bits shifted LSB first, then -> STOP.
REQ-014 STOP: sample after 16 ticks; 1 -> assert new_rx_data for exactly one clk with rx_data valid, then IDLE; 0 (framing error) -> byte discarded, no pulse, IDLE.
REQ-015 rx_data SHALL hold its value until the next valid byte.

Function -- decoder
REQ-016 Message format: channel char '0'..'6', hex-high char, hex-low char, terminator LF (0x0A).
REQ-017 Hex chars accepted: '0'-'9', 'A'-'F', 'a'-'f'.
REQ-018 CR (0x0D) bytes SHALL be ignored in every state (no state change).
REQ-019 Decoder states: WAIT_CH, WAIT_HI, WAIT_LO, WAIT_END; state advances only on new_rx_data cycles.
REQ-020 WAIT_CH: '0'..'6' -> store channel, WAIT_HI; any other byte -> stay.
REQ-021 WAIT_HI / WAIT_LO: valid hex -> store nibble, advance; invalid byte -> WAIT_CH, message discarded.
REQ-022 WAIT_END: LF -> out[channel] <= {hi,lo}, WAIT_CH; any other byte -> WAIT_CH, no update.
REQ-023 out[channel] SHALL update on the same clk edge that samples new_rx_data=1 with LF; visible the following cycle.
REQ-024 Only the addressed channel changes; all other out entries hold.
REQ-025 Channels '7'..'9' or letters in channel position are never accepted.
REQ-026 Invalid or aborted messages SHALL leave all outputs unchanged.

Reset
REQ-027 reset_n low SHALL immediately clear all out[0..6] to 8'h00, the tick counter to 0, the receiver to IDLE, and the decoder to WAIT_CH with stored channel/nibbles 0.
REQ-028 Reset asserted mid-byte or mid-message SHALL discard the partial data; the first complete message after release decodes normally.
REQ-029 No output changes while reset_n is low.

Verification
REQ-030 Reset, CTRL_RX held 1 -> all out = 0x00; ce_16 period 326 clk; no new_rx_data.
REQ-031 Send "3A5\n" at 9600 baud (5216 clk/bit) -> out[3]=0xA5 one clk after the LF pulse, others 0x00.
REQ-032 Send "1ff\r\n" then "7FF\n" -> out[1]=0xFF; channel-7 message ignored, all else unchanged.
REQ-033 Send "2G1\n" then "25" + 'X' -> no output change; next "20C\n" -> out[2]=0x0C.
REQ-034 Send a byte with stop bit 0 inside a message, and a 3-tick low glitch on idle line -> no new_rx_data pulse, no output change.
REQ-035 Assert reset_n low midway through the second char of "4 7E\n" -> outputs 0x00; after release "47E\n" -> out[4]=0x7E.
